// File: rtl/daq_link_packer.sv
// DAQ word packer: validates header/data/trailer framing, patches the trailer word count,
// buffers words in a 66-bit FIFO and drains them to the AMC13 link under backpressure.
module daq_link_packer #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] daq_data,
  input  logic        daq_header,
  input  logic        daq_trailer,
  input  logic        daq_valid,
  output logic        daq_ready,
  output logic [63:0] link_data,
  output logic        link_header,
  output logic        link_trailer,
  output logic        link_valid,
  input  logic        link_almost_full,
  input  logic        link_ready,
  output logic [31:0] event_count,
  output logic        err_sequence,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 66;
  localparam int unsigned WCW = 20;
  localparam logic [WCW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, IN_EVENT} state_t;

  state_t          state, state_nx;
  logic [WCW-1:0]  word_cnt, cnt_nx, cnt_inc;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nx;
  logic            accept, wr_en, pop, err_set, evt_inc, rd_valid;
  logic [EW-1:0]   wr_word, rd_word;

  assign daq_ready = !rst && (count != CW'(FIFO_DEPTH));
  assign accept    = daq_valid && daq_ready;
  assign pop       = (count != '0) && link_ready && !link_almost_full;
  assign cnt_inc   = (word_cnt == CNT_MAX) ? CNT_MAX : word_cnt + WCW'(1);
  assign count_nx  = count + CW'(wr_en) - CW'(pop);

  // Input framing FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_nx;
      word_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = word_cnt;
    wr_en    = 1'b0;
    wr_word  = {daq_header, daq_trailer, daq_data};
    err_set  = 1'b0;
    evt_inc  = 1'b0;
    if (accept) begin
      if (daq_header && daq_trailer) begin
        err_set = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (daq_header) begin
              wr_en    = 1'b1;
              cnt_nx   = WCW'(1);
              state_nx = IN_EVENT;
            end else begin
              err_set = 1'b1;
            end
          end
          IN_EVENT: begin
            wr_en = 1'b1;
            if (daq_header) begin
              // Restart on a stray header; the partial event leaves without a trailer
              err_set = 1'b1;
              cnt_nx  = WCW'(1);
            end else if (daq_trailer) begin
              wr_word  = {1'b0, 1'b1, daq_data[63:WCW], cnt_inc};
              cnt_nx   = cnt_inc;
              evt_inc  = 1'b1;
              state_nx = IDLE;
            end else begin
              cnt_nx = cnt_inc;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_count  <= '0;
      err_sequence <= 1'b0;
      busy         <= 1'b0;
    end else begin
      event_count <= event_count + 32'(evt_inc);
      if (err_set) err_sequence <= 1'b1;
      busy <= (state_nx == IN_EVENT) || (count_nx != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  // FIFO pointers and the two-stage registered read path to the link
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_valid     <= 1'b0;
      rd_word      <= '0;
      link_valid   <= 1'b0;
      link_header  <= 1'b0;
      link_trailer <= 1'b0;
      link_data    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_word <= mem[rd_ptr];
      end
      count      <= count_nx;
      rd_valid   <= pop;
      link_valid <= rd_valid;
      if (rd_valid) {link_header, link_trailer, link_data} <= rd_word;
    end
  end

endmodule

// File: tb/tb_daq_link_packer.sv
// Bench for daq_link_packer: directed framing/backpressure scenarios plus randomized events
// checked against a queue-based reference of the expected link word stream.
module tb_daq_link_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] daq_data = '0;
  logic        daq_header = 1'b0;
  logic        daq_trailer = 1'b0;
  logic        daq_valid = 1'b0;
  logic        daq_ready;
  logic [63:0] link_data;
  logic        link_header, link_trailer, link_valid;
  logic        link_almost_full = 1'b0;
  logic        link_ready = 1'b1;
  logic [31:0] event_count;
  logic        err_sequence, busy;

  daq_link_packer #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .daq_data(daq_data), .daq_header(daq_header), .daq_trailer(daq_trailer),
    .daq_valid(daq_valid), .daq_ready(daq_ready),
    .link_data(link_data), .link_header(link_header), .link_trailer(link_trailer),
    .link_valid(link_valid), .link_almost_full(link_almost_full), .link_ready(link_ready),
    .event_count(event_count), .err_sequence(err_sequence), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          out_cnt = 0;
  logic [65:0] exp_q[$];
  logic [63:0] last_trl = '0;
  bit          in_ev = 0;
  int          cnt = 0;
  int          exp_events = 0;
  bit          exp_err = 0;
  bit          rnd_bp = 0;
  logic [1:0]  af_s = '0;
  logic [1:0]  lr_s = '1;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: framing rules applied to each accepted word
  function automatic void model_accept(input logic h, input logic t, input logic [63:0] d);
    if (h && t) exp_err = 1;
    else if (h) begin
      if (in_ev) exp_err = 1;
      exp_q.push_back({2'b10, d});
      cnt = 1;
      in_ev = 1;
    end else if (!in_ev) exp_err = 1;
    else begin
      if (cnt < 1048575) cnt = cnt + 1;
      if (t) begin
        exp_q.push_back({2'b01, d[63:20], 20'(cnt)});
        exp_events++;
        in_ev = 0;
      end else exp_q.push_back({2'b00, d});
    end
  endfunction

  always @(posedge clk) begin
    af_s <= {af_s[0], link_almost_full};
    lr_s <= {lr_s[0], link_ready};
  end

  // Link-side monitor: every strobe must match the next expected word
  always @(negedge clk) begin
    if (!rst && link_valid) begin
      out_cnt++;
      if (link_trailer) last_trl = link_data;
      if (exp_q.size() == 0) chk("extra_link_word", 66'(exp_q.size()), 66'(1));
      else chk("link_word", {link_header, link_trailer, link_data}, exp_q.pop_front());
      chk("link_strobe_while_blocked", 66'(af_s[1] | !lr_s[1]), 66'(0));
    end
  end

  task automatic send(input logic h, input logic t, input logic [63:0] d);
    bit done = 0;
    bit acc;
    daq_header = h; daq_trailer = t; daq_data = d; daq_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      if (rnd_bp) begin
        link_almost_full = ($urandom_range(0, 3) == 0);
        link_ready = ($urandom_range(0, 7) != 0);
      end
      @(negedge clk);
      acc = daq_ready;
      @(posedge clk); #1;
      if (acc) begin
        model_accept(h, t, d);
        done = 1;
      end
    end
    daq_valid = 1'b0; daq_header = 1'b0; daq_trailer = 1'b0;
    if (!done) chk("send_timeout", 66'(done), 66'(1));
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_remaining", 66'(exp_q.size()), 66'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    in_ev = 0; cnt = 0; exp_events = 0; exp_err = 0;
    @(posedge clk); #1;
    chk("rst_daq_ready", 66'(daq_ready), 66'(0));
    chk("rst_link_valid", 66'(link_valid), 66'(0));
    chk("rst_link_flags", 66'({link_header, link_trailer}), 66'(0));
    chk("rst_link_data", 66'(link_data), 66'(0));
    chk("rst_event_count", 66'(event_count), 66'(0));
    chk("rst_err_sequence", 66'(err_sequence), 66'(0));
    chk("rst_busy", 66'(busy), 66'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_daq_ready", 66'(daq_ready), 66'(1));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] td;
    int base;
    int n;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic event: header, 3 data, trailer
    base = out_cnt;
    send(1, 0, rnd64());
    for (int i = 0; i < 3; i++) send(0, 0, rnd64());
    td = {rnd64()} | 64'h5;
    send(0, 1, td);
    drain();
    chk("basic_out_words", 66'(out_cnt - base), 66'(5));
    chk("basic_trl_count", 66'(last_trl[19:0]), 66'(20'h00005));
    chk("basic_trl_upper", 66'(last_trl[63:20]), 66'(td[63:20]));
    chk("basic_event_count", 66'(event_count), 66'(1));
    chk("basic_err", 66'(err_sequence), 66'(0));

    // Latency: accept at edge N -> strobe after edge N+2
    send(1, 0, rnd64());
    chk("lat_busy", 66'(busy), 66'(1));
    @(posedge clk); #1;
    chk("lat_n1_valid", 66'(link_valid), 66'(0));
    @(posedge clk); #1;
    chk("lat_n2_valid", 66'({link_valid, link_header}), 66'(2'b11));
    send(0, 1, rnd64());
    drain();
    chk("lat_trl_count", 66'(last_trl[19:0]), 66'(2));

    // Backpressure: fill the FIFO behind almost-full
    base = out_cnt;
    link_almost_full = 1'b1;
    send(1, 0, rnd64());
    for (int i = 0; i < 15; i++) send(0, 0, rnd64());
    chk("bp_full_ready", 66'(daq_ready), 66'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_output", 66'(out_cnt - base), 66'(0));
    link_almost_full = 1'b0;
    chk("bp_ready_before_pop", 66'(daq_ready), 66'(0));
    @(posedge clk); #1;
    chk("bp_ready_after_pop", 66'(daq_ready), 66'(1));
    for (int i = 0; i < 3; i++) send(0, 0, rnd64());
    send(0, 1, rnd64());
    drain();
    chk("bp_out_words", 66'(out_cnt - base), 66'(20));
    chk("bp_trl_count", 66'(last_trl[19:0]), 66'(20));

    // Randomized legal events under random link backpressure
    rnd_bp = 1;
    for (int e = 0; e < 25; e++) begin
      send(1, 0, rnd64());
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) send(0, 0, rnd64());
      send(0, 1, rnd64());
    end
    rnd_bp = 0;
    link_almost_full = 1'b0;
    link_ready = 1'b1;
    drain();
    chk("rnd_event_count", 66'(event_count), 66'(exp_events));
    chk("rnd_err", 66'(err_sequence), 66'(exp_err));

    // Sequence errors
    send(0, 0, rnd64());
    chk("seq_idle_data_err", 66'(err_sequence), 66'(1));
    send(1, 0, rnd64());
    send(0, 0, rnd64());
    send(1, 0, rnd64());
    send(0, 1, rnd64());
    send(1, 1, rnd64());
    drain();
    chk("seq_restart_trl_count", 66'(last_trl[19:0]), 66'(2));
    send(1, 0, rnd64());
    send(1, 1, rnd64());
    send(0, 1, rnd64());
    drain();
    chk("seq_both_flags_dropped", 66'(last_trl[19:0]), 66'(2));
    chk("seq_event_count", 66'(event_count), 66'(exp_events));
    chk("seq_err_sticky", 66'(err_sequence), 66'(1));

    // Reset mid-event
    link_ready = 1'b0;
    send(1, 0, rnd64());
    send(0, 0, rnd64());
    send(0, 0, rnd64());
    do_reset();
    link_ready = 1'b1;
    base = out_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_output", 66'(out_cnt - base), 66'(0));
    chk("mid_rst_event_count", 66'(event_count), 66'(0));
    chk("mid_rst_busy", 66'(busy), 66'(0));
    send(1, 0, rnd64());
    send(0, 0, rnd64());
    send(0, 0, rnd64());
    send(0, 1, rnd64());
    drain();
    chk("mid_rst_trl_count", 66'(last_trl[19:0]), 66'(4));
    chk("mid_rst_event_after", 66'(event_count), 66'(1));

    // Link down for 50 cycles, then back-to-back release
    link_ready = 1'b0;
    send(1, 0, rnd64());
    send(0, 0, rnd64());
    send(0, 1, rnd64());
    base = out_cnt;
    repeat (50) @(posedge clk);
    #1;
    chk("lr_hold_no_output", 66'(out_cnt - base), 66'(0));
    link_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("lr_back_to_back", 66'(link_valid), 66'(1));
    end
    @(posedge clk); #1;
    chk("lr_after_burst", 66'(link_valid), 66'(0));
    drain();
    chk("lr_out_words", 66'(out_cnt - base), 66'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
